// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_ARB_TAG_EN to send a tag byte (TAG_BASE + source index) ahead of every data byte.
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] TAG_BASE    = 8'h30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_en_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic                 timeout_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
`ifdef UART_ARB_TAG_EN
  localparam logic [2:0] TAG_LAUNCH = 3'd3;
  localparam logic [2:0] TAG_WAIT   = 3'd4;
`endif

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_found;
  logic [WD_W-1:0]  wd;
  logic             waiting;
  logic             wd_expired;
  logic [7:0]       src_byte [NUM_REQ];
  int unsigned      cand;
`ifdef UART_ARB_TAG_EN
  logic [7:0]       data_q;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign src_byte[g] = data_i[8*g +: 8];
  end

  // First requester at or above rr_ptr, wrapping past the top index.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

`ifdef UART_ARB_TAG_EN
  assign waiting = (state == WAIT_DONE) || (state == TAG_WAIT);
  assign tx_en_o = (state == LAUNCH) || (state == TAG_LAUNCH);
`else
  assign waiting = (state == WAIT_DONE);
  assign tx_en_o = (state == LAUNCH);
  logic unused_tag;
  assign unused_tag = ^TAG_BASE;
`endif

  // A done pulse in the expiry cycle wins over the watchdog.
  assign wd_expired = (wd == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_o  = waiting && wd_expired && !tx_done_i;
  assign ack_o      = (state == LAUNCH) ? grant_o : '0;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      grant_o   <= '0;
      tx_data_o <= '0;
      wd        <= '0;
`ifdef UART_ARB_TAG_EN
      data_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            win_idx <= pick_idx;
            grant_o <= NUM_REQ'(1) << pick_idx;
`ifdef UART_ARB_TAG_EN
            data_q    <= src_byte[pick_idx];
            tx_data_o <= TAG_BASE + 8'(pick_idx);
            state     <= TAG_LAUNCH;
`else
            tx_data_o <= src_byte[pick_idx];
            state     <= LAUNCH;
`endif
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_i || wd_expired) begin
            grant_o <= '0;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG_LAUNCH: begin
          wd    <= '0;
          state <= TAG_WAIT;
        end
        TAG_WAIT: begin
          if (tx_done_i) begin
            tx_data_o <= data_q;
            state     <= LAUNCH;
          end else if (wd_expired) begin
            grant_o <= '0;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
- Selects a requester, latches its byte and pulses the transmitter's enable.
- Holds off all other requesters until the transmitter's done pulse returns, then rotates priority.
- Sits between the system's byte producers and the en/data/done interface of the UART transmit block.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYC, 200000, clk cycles allowed between tx_en_o and tx_done_i before the frame is abandoned; must exceed one 10-bit frame time.
- TAG_BASE, 8'h30, tag byte base value; used only when UART_ARB_TAG_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  NUM_REQ  level request per source; held high until ack_o.
- data_i  input  NUM_REQ*8  byte per source; source k owns bits [8k+7:8k]; stable while req_i[k] is high.
- ack_o  output  NUM_REQ  one-cycle pulse; byte of that source has been captured and launched.
- grant_o  output  NUM_REQ  one-hot current owner; zero when idle.
- tx_en_o  output  1  one-cycle start pulse to the transmitter.
- tx_data_o  output  8  byte to the transmitter; valid in the tx_en_o cycle; held until the next launch.
- tx_done_i  input  1  one-cycle frame-complete pulse from the transmitter.
- busy_o  output  1  high in any state other than IDLE.
- timeout_o  output  1  one-cycle pulse when the watchdog abandons a frame.

Behaviour:
- Reset values: ack_o, grant_o, tx_en_o, busy_o and timeout_o are 0; tx_data_o is 8'h00; state is IDLE; rr_ptr is 0; watchdog is 0.
- Reset is honoured mid-frame: everything returns to reset values immediately. A tx_done_i arriving afterwards is ignored.
- States: IDLE, LAUNCH, WAIT_DONE (plus TAG_LAUNCH and TAG_WAIT under the optional feature).
- IDLE:
  - If req_i is non-zero, the winner is the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 back to 0.
  - In the same edge: latch the winner's byte into tx_data_o, set the grant_o bit, go to LAUNCH.
  - req_i is sampled only in IDLE.
- LAUNCH (exactly one cycle):
  - tx_en_o=1 and ack_o[winner]=1.
  - Clear the watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On tx_done_i: clear grant_o, set rr_ptr = winner+1 (wrap to 0 past NUM_REQ-1), go to IDLE.
  - If the watchdog reaches TIMEOUT_CYC-1 without tx_done_i: pulse timeout_o, perform the same release and rotation, go to IDLE.
  - tx_done_i in any other state is ignored.
- Latency: req_i asserted in IDLE gives tx_en_o two edges later (cycle N sample, N+1 LAUNCH). tx_done_i at cycle M allows the next tx_en_o no earlier than M+2.
- Requester side:
  - A requester holding req_i high after ack_o gets its next byte only after all other pending requesters have been served once.
  - A single requester alone streams back-to-back frames.
  - Dropping req_i before grant is legal: that source is simply skipped.
  - Dropping req_i after grant has no effect; the byte is already latched.
- Simultaneous tx_done_i and watchdog expiry: treated as done; no timeout_o pulse.

Optional Feature:
- Macro UART_ARB_TAG_EN.
- When defined, each grant first sends a tag byte (TAG_BASE + winner index) and then the data byte:
  - IDLE → TAG_LAUNCH (tx_en_o with tag, no ack) → TAG_WAIT (waits tx_done_i, watchdog active) → LAUNCH → WAIT_DONE.
  - grant_o is held across both frames; ack_o pulses only in LAUNCH.
  - A timeout in TAG_WAIT releases the grant without sending the data byte or pulsing ack_o.
- When not defined: only the data frame is sent; TAG_BASE is unused and the tag states are absent.

Test Plan:
- Reset mid-WAIT_DONE with grant_o=4'b0010 → all outputs 0 and rr_ptr=0 on the next edge. A later tx_done_i pulse produces no activity.
- req_i=4'b0100, data byte 8'hA5 → tx_en_o two cycles later with tx_data_o=8'hA5, ack_o=4'b0100 in the same cycle, busy_o held until tx_done_i.
- req_i=4'b1111 held, bytes 8'h11/8'h22/8'h33/8'h44, done returned 20 cycles after each launch → launch order 11,22,33,44,11; grants 0,1,2,3,0.
- Single requester 3 held, tx_done_i every 20 cycles → tx_en_o every 22 cycles, ack_o[3] each time.
- TIMEOUT_CYC=50 and tx_done_i never asserted → timeout_o pulse 50 cycles after tx_en_o, grant released, next requester served.
- With UART_ARB_TAG_EN and req_i=4'b0010, byte 8'h7E → frames 8'h31 then 8'h7E; ack_o[1] pulses only with the 8'h7E launch.
